mem_stage: RTL and testbench

- Memory-access pipeline stage between the execute stage and the write-back stage of the 5-stage in-order CPU.
- Holds one instruction and waits for the data-SRAM read response when the instruction is a load.
- Aligns and sign- or zero-extends load data, then hands {pc, wdata, waddr, we} to write-back under valid/allowin handshake.
- Exports a forwarding/bypass view to the decode stage, including a load-not-ready block flag.

---
 rtl/cpu_defs.sv | 27 ++
 rtl/mem_stage_if.sv | 46 ++++
 rtl/mem_stage_load_align.sv | 33 +++
 rtl/mem_stage.sv | 106 ++++++++++
 tb/tb_mem_stage.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared CPU datapath widths, load-op codes and memory-stage types
package cpu_defs;

    localparam int DATA_W    = 32;
    localparam int REG_IDX_W = 5;

    localparam logic [2:0] LD_OP_W  = 3'd0;
    localparam logic [2:0] LD_OP_B  = 3'd1;
    localparam logic [2:0] LD_OP_H  = 3'd2;
    localparam logic [2:0] LD_OP_BU = 3'd3;
    localparam logic [2:0] LD_OP_HU = 3'd4;

    typedef enum logic {
        BUF_WAIT = 1'b0,
        BUF_HAVE = 1'b1
    } buf_state_e;

    typedef struct packed {
        logic [DATA_W-1:0]    pc;
        logic [DATA_W-1:0]    alu_result;
        logic [REG_IDX_W-1:0] rf_waddr;
        logic                 rf_we;
        logic                 res_from_mem;
        logic [2:0]           ld_op;
    } ms_payload_t;

endpackage

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - execute->memory and memory->write-back stage handshake bundles
interface es_ms_if;
    import cpu_defs::*;

    logic                 es_to_ms_valid;
    logic                 ms_allowin;
    logic [DATA_W-1:0]    es_pc;
    logic [DATA_W-1:0]    es_alu_result;
    logic [REG_IDX_W-1:0] es_rf_waddr;
    logic                 es_rf_we;
    logic                 es_res_from_mem;
    logic [2:0]           es_ld_op;

    modport master (
        output es_to_ms_valid, es_pc, es_alu_result, es_rf_waddr,
               es_rf_we, es_res_from_mem, es_ld_op,
        input  ms_allowin
    );

    modport slave (
        input  es_to_ms_valid, es_pc, es_alu_result, es_rf_waddr,
               es_rf_we, es_res_from_mem, es_ld_op,
        output ms_allowin
    );
endinterface

interface ms_ws_if;
    import cpu_defs::*;

    logic                 ms_to_ws_valid;
    logic                 ws_allowin;
    logic [DATA_W-1:0]    ms_pc;
    logic [DATA_W-1:0]    ms_rf_wdata;
    logic [REG_IDX_W-1:0] ms_rf_waddr;
    logic                 ms_rf_we;

    modport master (
        output ms_to_ws_valid, ms_pc, ms_rf_wdata, ms_rf_waddr, ms_rf_we,
        input  ws_allowin
    );

    modport slave (
        input  ms_to_ws_valid, ms_pc, ms_rf_wdata, ms_rf_waddr, ms_rf_we,
        output ws_allowin
    );
endinterface

// File: rtl/mem_stage_load_align.sv
// rtl/mem_stage_load_align.sv - selects and extends the byte/halfword/word of a load response
module load_align
    import cpu_defs::*;
(
    input  logic [2:0]        ld_op,
    input  logic [1:0]        offset,
    input  logic [DATA_W-1:0] word,
    output logic [DATA_W-1:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (offset)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        // offset[0] is ignored for halfwords; misaligned accesses trap before this stage
        half_sel = offset[1] ? word[31:16] : word[15:0];

        case (ld_op)
            LD_OP_B:  result = {{24{byte_sel[7]}}, byte_sel};
            LD_OP_BU: result = {24'h0, byte_sel};
            LD_OP_H:  result = {{16{half_sel[15]}}, half_sel};
            LD_OP_HU: result = {16'h0, half_sel};
            default:  result = word;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage: load response wait/buffer, alignment, bypass
module mem_stage
    import cpu_defs::*;
(
    input  logic                 clk,
    input  logic                 resetn,
    es_ms_if.slave               es,
    ms_ws_if.master              ws,
    input  logic                 data_sram_data_ok,
    input  logic [DATA_W-1:0]    data_sram_rdata,
    output logic                 ms_fwd_we,
    output logic [REG_IDX_W-1:0] ms_fwd_waddr,
    output logic [DATA_W-1:0]    ms_fwd_wdata,
    output logic                 ms_fwd_blk
);

    logic        ms_valid_q, ms_valid_d;
    ms_payload_t payload_q, payload_d;
    buf_state_e  buf_state_q, buf_state_d;
    logic [DATA_W-1:0] buf_data_q, buf_data_d;

    logic              buf_have;
    logic              ms_ready_go;
    logic              ms_leave;
    logic [DATA_W-1:0] load_word;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] rf_wdata;

    assign buf_have    = (buf_state_q == BUF_HAVE);
    assign ms_ready_go = !payload_q.res_from_mem | data_sram_data_ok | buf_have;
    assign es.ms_allowin = !ms_valid_q | (ms_ready_go & ws.ws_allowin);
    assign ws.ms_to_ws_valid = ms_valid_q & ms_ready_go;
    assign ms_leave    = ws.ms_to_ws_valid & ws.ws_allowin;

    always_comb begin
        ms_valid_d = ms_valid_q;
        payload_d  = payload_q;
        if (es.ms_allowin) begin
            ms_valid_d = es.es_to_ms_valid;
        end
        if (es.es_to_ms_valid & es.ms_allowin) begin
            payload_d = '{pc:           es.es_pc,
                          alu_result:   es.es_alu_result,
                          rf_waddr:     es.es_rf_waddr,
                          rf_we:        es.es_rf_we,
                          res_from_mem: es.es_res_from_mem,
                          ld_op:        es.es_ld_op};
        end
    end

    // The response is held only when write-back refuses it in its arrival cycle.
    always_comb begin
        buf_state_d = buf_state_q;
        buf_data_d  = buf_data_q;
        case (buf_state_q)
            BUF_WAIT: begin
                if (ms_valid_q & payload_q.res_from_mem & data_sram_data_ok & !ws.ws_allowin) begin
                    buf_state_d = BUF_HAVE;
                    buf_data_d  = data_sram_rdata;
                end
            end
            BUF_HAVE: begin
                if (ms_leave) begin
                    buf_state_d = BUF_WAIT;
                end
            end
            default: buf_state_d = BUF_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ms_valid_q  <= 1'b0;
            payload_q   <= '0;
            buf_state_q <= BUF_WAIT;
            buf_data_q  <= '0;
        end else begin
            ms_valid_q  <= ms_valid_d;
            payload_q   <= payload_d;
            buf_state_q <= buf_state_d;
            buf_data_q  <= buf_data_d;
        end
    end

    assign load_word = buf_have ? buf_data_q : data_sram_rdata;

    load_align u_load_align (
        .ld_op  (payload_q.ld_op),
        .offset (payload_q.alu_result[1:0]),
        .word   (load_word),
        .result (load_data)
    );

    assign rf_wdata = payload_q.res_from_mem ? load_data : payload_q.alu_result;

    assign ws.ms_pc       = payload_q.pc;
    assign ws.ms_rf_wdata = rf_wdata;
    assign ws.ms_rf_waddr = payload_q.rf_waddr;
    assign ws.ms_rf_we    = payload_q.rf_we;

    assign ms_fwd_we    = ms_valid_q & payload_q.rf_we;
    assign ms_fwd_waddr = payload_q.rf_waddr;
    assign ms_fwd_wdata = rf_wdata;
    assign ms_fwd_blk   = ms_valid_q & payload_q.res_from_mem & !buf_have & !data_sram_data_ok;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage
module tb_mem_stage;
    import cpu_defs::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        data_ok;
    logic [31:0] rdata;
    logic        fwd_we;
    logic [4:0]  fwd_waddr;
    logic [31:0] fwd_wdata;
    logic        fwd_blk;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    es_ms_if es_if();
    ms_ws_if ws_if();

    mem_stage dut (
        .clk               (clk),
        .resetn            (resetn),
        .es                (es_if),
        .ws                (ws_if),
        .data_sram_data_ok (data_ok),
        .data_sram_rdata   (rdata),
        .ms_fwd_we         (fwd_we),
        .ms_fwd_waddr      (fwd_waddr),
        .ms_fwd_wdata      (fwd_wdata),
        .ms_fwd_blk        (fwd_blk)
    );

    typedef struct {
        logic [2:0]  op;
        logic [1:0]  off;
        logic [31:0] word;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] alu;
        logic [4:0]  waddr;
        logic        we;
        logic        ld;
        logic [2:0]  op;
    } inst_t;

    vec_t vecs[10];

    // reference model state: the one instruction held, plus its load data once known
    logic        m_have;
    inst_t       m_inst;
    logic        m_dk;
    logic [31:0] m_dv;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_align(input logic [2:0] op, input logic [1:0] off,
                                              input logic [31:0] word);
        logic [31:0] sh;
        logic [31:0] r;
        if (op == 3'd1 || op == 3'd3) begin
            sh = word >> (8 * int'(off));
            r  = sh & 32'h0000_00FF;
            if (op == 3'd1 && sh[7]) r = r | 32'hFFFF_FF00;
        end else if (op == 3'd2 || op == 3'd4) begin
            sh = word >> (16 * int'(off[1]));
            r  = sh & 32'h0000_FFFF;
            if (op == 3'd2 && sh[15]) r = r | 32'hFFFF_0000;
        end else begin
            r = word;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        es_if.es_to_ms_valid  = 1'b0;
        es_if.es_pc           = '0;
        es_if.es_alu_result   = '0;
        es_if.es_rf_waddr     = '0;
        es_if.es_rf_we        = 1'b0;
        es_if.es_res_from_mem = 1'b0;
        es_if.es_ld_op        = '0;
        ws_if.ws_allowin      = 1'b1;
        data_ok               = 1'b0;
        rdata                 = '0;
    endtask

    task automatic send(input logic [31:0] pc, input logic [31:0] alu, input logic [4:0] wa,
                        input logic we, input logic ld, input logic [2:0] op);
        es_if.es_to_ms_valid  = 1'b1;
        es_if.es_pc           = pc;
        es_if.es_alu_result   = alu;
        es_if.es_rf_waddr     = wa;
        es_if.es_rf_we        = we;
        es_if.es_res_from_mem = ld;
        es_if.es_ld_op        = op;
    endtask

    task automatic check_empty(input string tag);
        check({tag, ".allowin"}, 32'(es_if.ms_allowin), 32'd1);
        check({tag, ".to_ws"},   32'(ws_if.ms_to_ws_valid), 32'd0);
        check({tag, ".fwd_we"},  32'(fwd_we), 32'd0);
        check({tag, ".fwd_blk"}, 32'(fwd_blk), 32'd0);
    endtask

    initial begin
        idle();
        vecs[0] = '{LD_OP_B,  2'd3, 32'h80FF1234, 32'hFFFFFF80};
        vecs[1] = '{LD_OP_BU, 2'd3, 32'h80FF1234, 32'h00000080};
        vecs[2] = '{LD_OP_H,  2'd2, 32'h80FF1234, 32'hFFFF80FF};
        vecs[3] = '{LD_OP_HU, 2'd0, 32'h80FF1234, 32'h00001234};
        vecs[4] = '{LD_OP_W,  2'd1, 32'h80FF1234, 32'h80FF1234};
        vecs[5] = '{LD_OP_B,  2'd1, 32'h80FF1234, 32'h00000012};
        vecs[6] = '{LD_OP_H,  2'd3, 32'h80FF1234, 32'hFFFF80FF};
        vecs[7] = '{3'd7,     2'd2, 32'h80FF1234, 32'h80FF1234};
        vecs[8] = '{LD_OP_HU, 2'd2, 32'h80FF1234, 32'h000080FF};
        vecs[9] = '{LD_OP_B,  2'd0, 32'h0000007F, 32'h0000007F};

        tick();
        tick();
        @(negedge clk);
        check_empty("reset");
        check("reset.pc",    ws_if.ms_pc, 32'h0);
        check("reset.wdata", ws_if.ms_rf_wdata, 32'h0);
        check("reset.waddr", 32'(ws_if.ms_rf_waddr), 32'h0);
        tick();
        resetn = 1'b1;

        // ALU pass-through
        send(32'h1C000000, 32'h12345678, 5'd5, 1'b1, 1'b0, LD_OP_W);
        tick();
        idle();
        @(negedge clk);
        check("alu.to_ws",   32'(ws_if.ms_to_ws_valid), 32'd1);
        check("alu.pc",      ws_if.ms_pc, 32'h1C000000);
        check("alu.wdata",   ws_if.ms_rf_wdata, 32'h12345678);
        check("alu.waddr",   32'(ws_if.ms_rf_waddr), 32'd5);
        check("alu.fwd_we",  32'(fwd_we), 32'd1);
        check("alu.fwd_blk", 32'(fwd_blk), 32'd0);
        check("alu.fwd_wd",  fwd_wdata, 32'h12345678);
        tick();

        // load alignment table, data_ok in the first cycle after capture
        for (int i = 0; i < 10; i++) begin
            send(32'h1C000100 + 32'(i * 4), 32'h00002000 | 32'(vecs[i].off), 5'd9, 1'b1, 1'b1, vecs[i].op);
            tick();
            idle();
            data_ok = 1'b1;
            rdata   = vecs[i].word;
            @(negedge clk);
            check($sformatf("ld%0d.to_ws", i), 32'(ws_if.ms_to_ws_valid), 32'd1);
            check($sformatf("ld%0d.wdata", i), ws_if.ms_rf_wdata, vecs[i].exp);
            check($sformatf("ld%0d.fwd_wd", i), fwd_wdata, vecs[i].exp);
            check($sformatf("ld%0d.blk", i), 32'(fwd_blk), 32'd0);
            tick();
            idle();
        end

        // delayed data_ok: two stalled cycles, then released in the data_ok cycle
        send(32'h1C000200, 32'h00003000, 5'd7, 1'b1, 1'b1, LD_OP_W);
        tick();
        send(32'h1C000204, 32'h0000AAAA, 5'd8, 1'b1, 1'b0, LD_OP_W);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("dly.blk",     32'(fwd_blk), 32'd1);
            check("dly.allowin", 32'(es_if.ms_allowin), 32'd0);
            check("dly.to_ws",   32'(ws_if.ms_to_ws_valid), 32'd0);
            tick();
        end
        data_ok = 1'b1;
        rdata   = 32'h11223344;
        @(negedge clk);
        check("dly.ok.to_ws", 32'(ws_if.ms_to_ws_valid), 32'd1);
        check("dly.ok.blk",   32'(fwd_blk), 32'd0);
        check("dly.ok.wdata", ws_if.ms_rf_wdata, 32'h11223344);
        check("dly.ok.allow", 32'(es_if.ms_allowin), 32'd1);
        tick();
        idle();
        @(negedge clk);
        check("dly.next.pc",    ws_if.ms_pc, 32'h1C000204);
        check("dly.next.wdata", ws_if.ms_rf_wdata, 32'h0000AAAA);
        tick();

        // response buffered while write-back stalls
        send(32'h1C000300, 32'h00004000, 5'd3, 1'b1, 1'b1, LD_OP_W);
        tick();
        idle();
        ws_if.ws_allowin = 1'b0;
        data_ok = 1'b1;
        rdata   = 32'hCAFEF00D;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("buf.to_ws",   32'(ws_if.ms_to_ws_valid), 32'd1);
            check("buf.wdata",   ws_if.ms_rf_wdata, 32'hCAFEF00D);
            check("buf.allowin", 32'(es_if.ms_allowin), 32'd0);
            check("buf.blk",     32'(fwd_blk), 32'd0);
            tick();
            data_ok = 1'b0;
            rdata   = 32'hDEADBEEF;
        end
        ws_if.ws_allowin = 1'b1;
        @(negedge clk);
        check("buf.rel.wdata", ws_if.ms_rf_wdata, 32'hCAFEF00D);
        check("buf.rel.allow", 32'(es_if.ms_allowin), 32'd1);
        tick();
        @(negedge clk);
        check("buf.gone", 32'(ws_if.ms_to_ws_valid), 32'd0);
        tick();

        // back-to-back ALU, load, ALU without bubbles
        send(32'h1C000400, 32'h00000111, 5'd1, 1'b1, 1'b0, LD_OP_W);
        tick();
        send(32'h1C000404, 32'h00005002, 5'd2, 1'b1, 1'b1, LD_OP_HU);
        @(negedge clk);
        check("b2b.0.valid", 32'(ws_if.ms_to_ws_valid), 32'd1);
        check("b2b.0.pc",    ws_if.ms_pc, 32'h1C000400);
        tick();
        send(32'h1C000408, 32'h00000333, 5'd3, 1'b1, 1'b0, LD_OP_W);
        data_ok = 1'b1;
        rdata   = 32'hBEEF0000;
        @(negedge clk);
        check("b2b.1.valid", 32'(ws_if.ms_to_ws_valid), 32'd1);
        check("b2b.1.pc",    ws_if.ms_pc, 32'h1C000404);
        check("b2b.1.wdata", ws_if.ms_rf_wdata, 32'h0000BEEF);
        tick();
        idle();
        @(negedge clk);
        check("b2b.2.valid", 32'(ws_if.ms_to_ws_valid), 32'd1);
        check("b2b.2.pc",    ws_if.ms_pc, 32'h1C000408);
        tick();

        // reset while a buffered load waits
        send(32'h1C000500, 32'h00006000, 5'd4, 1'b1, 1'b1, LD_OP_W);
        tick();
        idle();
        ws_if.ws_allowin = 1'b0;
        data_ok = 1'b1;
        rdata   = 32'h55667788;
        tick();
        data_ok = 1'b0;
        resetn  = 1'b0;
        tick();
        ws_if.ws_allowin = 1'b1;
        @(negedge clk);
        check_empty("rst2");
        check("rst2.pc",    ws_if.ms_pc, 32'h0);
        check("rst2.wdata", ws_if.ms_rf_wdata, 32'h0);
        tick();
        resetn = 1'b1;
        send(32'h1C000600, 32'h00007000, 5'd6, 1'b1, 1'b1, LD_OP_W);
        tick();
        idle();
        @(negedge clk);
        check("rst2.blk", 32'(fwd_blk), 32'd1);
        check("rst2.to_ws", 32'(ws_if.ms_to_ws_valid), 32'd0);
        data_ok = 1'b1;
        rdata   = 32'h0BADF00D;
        tick();
        idle();

        // randomized traffic against the reference model
        m_have = 1'b0;
        m_dk   = 1'b0;
        m_dv   = '0;
        m_inst = '{default: '0};
        for (int c = 0; c < 600; c++) begin
            logic        ready, allow, leave;
            logic [31:0] exp_wd;
            inst_t       n;
            n.pc    = $urandom;
            n.alu   = $urandom;
            n.waddr = 5'($urandom);
            n.we    = 1'($urandom);
            n.ld    = ($urandom_range(0, 1) == 1);
            n.op    = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) send(n.pc, n.alu, n.waddr, n.we, n.ld, n.op);
            else es_if.es_to_ms_valid = 1'b0;
            ws_if.ws_allowin = ($urandom_range(0, 9) < 7);
            data_ok = m_have && m_inst.ld && !m_dk && ($urandom_range(0, 1) == 1);
            rdata   = $urandom;
            @(negedge clk);
            ready = !m_inst.ld || m_dk || data_ok;
            allow = !m_have || (ready && ws_if.ws_allowin);
            leave = m_have && ready && ws_if.ws_allowin;
            check("rnd.allowin", 32'(es_if.ms_allowin), 32'(allow));
            check("rnd.to_ws",   32'(ws_if.ms_to_ws_valid), 32'(m_have && ready));
            check("rnd.blk",     32'(fwd_blk), 32'(m_have && m_inst.ld && !m_dk && !data_ok));
            check("rnd.fwd_we",  32'(fwd_we), 32'(m_have && m_inst.we));
            if (m_have) begin
                exp_wd = m_inst.ld ? ref_align(m_inst.op, m_inst.alu[1:0], m_dk ? m_dv : rdata)
                                   : m_inst.alu;
                check("rnd.pc",    ws_if.ms_pc, m_inst.pc);
                check("rnd.waddr", 32'(ws_if.ms_rf_waddr), 32'(m_inst.waddr));
                check("rnd.wdata", ws_if.ms_rf_wdata, exp_wd);
                check("rnd.fwd_wd", fwd_wdata, exp_wd);
            end
            if (m_have && m_inst.ld && !m_dk && data_ok && !leave) begin
                m_dk = 1'b1;
                m_dv = rdata;
            end
            if (allow) begin
                m_have = es_if.es_to_ms_valid;
                m_dk   = 1'b0;
                if (es_if.es_to_ms_valid) m_inst = n;
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
